// File: rtl/tftlcd_rx.sv
// DE-mode RGB panel receiver: finds frames from the DEN-low vertical blank, regenerates
// pixel coordinates, emits a qualified pixel stream and checks line/frame geometry.
module tftlcd_rx #(
  parameter int X_PX              = 800,
  parameter int Y_PX              = 480,
  parameter int VBLANK_MIN_CYCLES = 8000,
  parameter int GAP_W             = 20
) (
  input  logic        i_CLK,
  input  logic        i_Reset,
  input  logic [7:0]  i_R,
  input  logic [7:0]  i_G,
  input  logic [7:0]  i_B,
  input  logic        i_DEN,
  input  logic        i_STBYB,
  output logic [23:0] o_RGB,
  output logic        o_Valid,
  output logic [15:0] o_XPx,
  output logic [15:0] o_YPx,
  output logic        o_SOF,
  output logic        o_EOL,
  output logic        o_EOF,
  output logic        o_Locked,
  output logic        o_LineErr,
  output logic        o_FrameErr
);

  localparam logic [15:0]      X_COUNT    = 16'(X_PX);
  localparam logic [15:0]      X_LAST     = 16'(X_PX - 1);
  localparam logic [15:0]      Y_COUNT    = 16'(Y_PX);
  localparam logic [15:0]      Y_LAST     = 16'(Y_PX - 1);
  localparam logic [GAP_W-1:0] GAP_VBLANK = GAP_W'(VBLANK_MIN_CYCLES);
  localparam logic [GAP_W-1:0] GAP_MAX    = {GAP_W{1'b1}};

  typedef enum logic [1:0] {SEARCH, FRAME_WAIT, LINE, BLANK} state_t;

  // Reset asserts asynchronously and releases on a clock edge.
  logic rst_meta_reg, rst_sync_reg;
  always_ff @(posedge i_CLK or posedge i_Reset) begin
    if (i_Reset) begin
      rst_meta_reg <= 1'b1;
      rst_sync_reg <= 1'b1;
    end else begin
      rst_meta_reg <= 1'b0;
      rst_sync_reg <= rst_meta_reg;
    end
  end

  logic [23:0] rgb1_reg;
  logic        den1_reg, stby1_reg;
  always_ff @(posedge i_CLK or posedge rst_sync_reg) begin
    if (rst_sync_reg) begin
      rgb1_reg  <= '0;
      den1_reg  <= 1'b0;
      stby1_reg <= 1'b0;
    end else begin
      rgb1_reg  <= {i_R, i_G, i_B};
      den1_reg  <= i_DEN;
      stby1_reg <= i_STBYB;
    end
  end

  state_t           state_reg, state_next;
  logic [GAP_W-1:0] gap_reg, gap_next, gap_now;
  logic [15:0]      x_reg, x_next, y_reg, y_next;
  logic             frame_bad_reg, frame_bad_next;
  logic             vblank_hit;

  // Gap including the current stage-1 sample.
  assign gap_now    = den1_reg ? '0 : ((gap_reg == GAP_MAX) ? gap_reg : gap_reg + GAP_W'(1));
  assign vblank_hit = (gap_now >= GAP_VBLANK);

  always_ff @(posedge i_CLK or posedge rst_sync_reg) begin
    if (rst_sync_reg) state_reg <= SEARCH;
    else              state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (!stby1_reg) begin
      state_next = SEARCH;
    end else begin
      case (state_reg)
        SEARCH:     if (vblank_hit) state_next = FRAME_WAIT;
        FRAME_WAIT: if (den1_reg) state_next = LINE;
        LINE:       if (!den1_reg) state_next = BLANK;
        BLANK: begin
          if (den1_reg)        state_next = LINE;
          else if (vblank_hit) state_next = FRAME_WAIT;
        end
        default:    state_next = SEARCH;
      endcase
    end
  end

  logic [23:0] rgb_reg;
  logic [15:0] xpx_reg, xpx_next, ypx_reg, ypx_next;
  logic        valid_reg, valid_next, sof_reg, sof_next, eol_reg, eol_next, eof_reg, eof_next;
  logic        locked_reg, locked_next, line_err_reg, line_err_next, frame_err_reg, frame_err_next;
  logic        pixel_en;
  logic [15:0] pix_x, pix_y;

  always_comb begin
    gap_next       = gap_now;
    x_next         = x_reg;
    y_next         = y_reg;
    frame_bad_next = frame_bad_reg;
    locked_next    = locked_reg;
    xpx_next       = xpx_reg;
    ypx_next       = ypx_reg;
    valid_next     = 1'b0;
    sof_next       = 1'b0;
    eol_next       = 1'b0;
    eof_next       = 1'b0;
    line_err_next  = 1'b0;
    frame_err_next = 1'b0;
    pixel_en       = 1'b0;
    pix_x          = '0;
    pix_y          = '0;
    if (!stby1_reg) begin
      gap_next       = '0;
      x_next         = '0;
      y_next         = '0;
      frame_bad_next = 1'b0;
      locked_next    = 1'b0;
    end else begin
      case (state_reg)
        FRAME_WAIT: if (den1_reg) begin
          pixel_en       = 1'b1;
          y_next         = '0;
          frame_bad_next = 1'b0;
        end
        LINE: begin
          if (den1_reg) begin
            pixel_en = 1'b1;
            pix_x    = x_reg;
            pix_y    = y_reg;
          end else begin
            line_err_next  = (x_reg != X_COUNT);
            frame_bad_next = frame_bad_reg | (x_reg != X_COUNT);
            y_next         = (y_reg == 16'hFFFF) ? y_reg : y_reg + 16'd1;
          end
        end
        BLANK: begin
          if (den1_reg) begin
            pixel_en = 1'b1;
            pix_y    = y_reg;
          end else if (vblank_hit) begin
            frame_err_next = (y_reg != Y_COUNT);
            locked_next    = (y_reg == Y_COUNT) && !frame_bad_reg;
          end
        end
        default: ;
      endcase
      if (pixel_en) begin
        x_next = (pix_x == 16'hFFFF) ? pix_x : pix_x + 16'd1;
        if (pix_x < X_COUNT && pix_y < Y_COUNT) begin
          valid_next = 1'b1;
          xpx_next   = pix_x;
          ypx_next   = pix_y;
          sof_next   = (pix_x == 16'd0) && (pix_y == 16'd0);
          eol_next   = (pix_x == X_LAST);
          eof_next   = (pix_x == X_LAST) && (pix_y == Y_LAST);
        end
      end
    end
  end

  always_ff @(posedge i_CLK or posedge rst_sync_reg) begin
    if (rst_sync_reg) begin
      gap_reg       <= '0;
      x_reg         <= '0;
      y_reg         <= '0;
      frame_bad_reg <= 1'b0;
      rgb_reg       <= '0;
      xpx_reg       <= '0;
      ypx_reg       <= '0;
      valid_reg     <= 1'b0;
      sof_reg       <= 1'b0;
      eol_reg       <= 1'b0;
      eof_reg       <= 1'b0;
      locked_reg    <= 1'b0;
      line_err_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      gap_reg       <= gap_next;
      x_reg         <= x_next;
      y_reg         <= y_next;
      frame_bad_reg <= frame_bad_next;
      rgb_reg       <= rgb1_reg;
      xpx_reg       <= xpx_next;
      ypx_reg       <= ypx_next;
      valid_reg     <= valid_next;
      sof_reg       <= sof_next;
      eol_reg       <= eol_next;
      eof_reg       <= eof_next;
      locked_reg    <= locked_next;
      line_err_reg  <= line_err_next;
      frame_err_reg <= frame_err_next;
    end
  end

  assign o_RGB      = rgb_reg;
  assign o_Valid    = valid_reg;
  assign o_XPx      = xpx_reg;
  assign o_YPx      = ypx_reg;
  assign o_SOF      = sof_reg;
  assign o_EOL      = eol_reg;
  assign o_EOF      = eof_reg;
  assign o_Locked   = locked_reg;
  assign o_LineErr  = line_err_reg;
  assign o_FrameErr = frame_err_reg;

endmodule

// File: doc/tftlcd_rx.md
Name: tftlcd_rx

Overview:
- Receiver for the DE-mode parallel RGB panel interface driven by our TFT timing generator.
- Samples R/G/B/DEN/STBYB and finds frame boundaries from the long DEN-low vertical-blank gap, since the link carries no usable HSD/VSD.
- Regenerates pixel X/Y coordinates and emits a qualified pixel stream with SOF/EOL/EOF markers.
- Checks line length and line count against the configured geometry.
- Used as the capture front end for the loopback/bench path and as the verification monitor for the panel driver.

Parameters:
- X_PX, 800: active pixels per line.
- Y_PX, 480: active lines per frame.
- VBLANK_MIN_CYCLES, 8000: consecutive DEN-low cycles that mark vertical blank. Must exceed the longest horizontal blank (3900 at default timing).
- GAP_W, 20: width of the gap counter. The counter saturates at 2^GAP_W-1.

Ports:
- i_CLK  in  1  pixel clock; all logic on rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_R  in  8  red.
- i_G  in  8  green.
- i_B  in  8  blue.
- i_DEN  in  1  data enable.
- i_STBYB  in  1  1 = normal, 0 = standby.
- o_RGB  out  24  {R,G,B} of the current pixel.
- o_Valid  out  1  pixel qualifier.
- o_XPx  out  16  pixel column.
- o_YPx  out  16  pixel row.
- o_SOF  out  1  with pixel (0,0).
- o_EOL  out  1  with pixel X_PX-1 of any line.
- o_EOF  out  1  with pixel (X_PX-1, Y_PX-1).
- o_Locked  out  1  last completed frame matched geometry.
- o_LineErr  out  1  one-cycle pulse: bad line length.
- o_FrameErr  out  1  one-cycle pulse: bad line count.

Behaviour:
- Reset: all outputs 0, state SEARCH, counters 0. Asynchronous assert, synchronous release.
- Input stage: R/G/B/DEN/STBYB are registered once (stage 1). Outputs are registered from stage 1.
- Latency: a pixel present at the inputs at edge k appears on o_RGB/o_Valid after edge k+1. Fixed at 2 edges and never stalls.
- Standby: stage-1 STBYB = 0 forces state SEARCH, clears counters, o_Locked = 0, o_Valid = 0 on the next edge. Takes priority over every other transition.
- Gap counter: counts consecutive stage-1 DEN-low cycles, saturating. Cleared on any DEN-high cycle.
- SEARCH: pixels ignored (o_Valid = 0). When gap reaches VBLANK_MIN_CYCLES -> FRAME_WAIT.
- FRAME_WAIT: on DEN rising: X = 0, Y = 0, o_SOF = 1 with that pixel -> LINE.
- LINE, per DEN-high cycle:
  - If X < X_PX and Y < Y_PX: o_Valid = 1, o_XPx = X, o_YPx = Y. Otherwise the pixel is dropped (o_Valid = 0).
  - X increments and saturates at 16'hFFFF.
  - o_EOL with X == X_PX-1. o_EOF additionally requires Y == Y_PX-1.
- LINE, on DEN falling:
  - If pixel count != X_PX, o_LineErr pulses.
  - Y increments (saturating) -> BLANK.
- BLANK:
  - DEN rising with gap < VBLANK_MIN_CYCLES: new line, X = 0 -> LINE.
  - Gap reaching VBLANK_MIN_CYCLES ends the frame:
    - line count == Y_PX and no line error in the frame: o_Locked = 1.
    - line count != Y_PX: o_FrameErr pulses and o_Locked = 0.
    - line error in the frame but correct line count: o_Locked = 0, no o_FrameErr.
    - In all cases -> FRAME_WAIT.
- SOF/EOL/EOF are only ever asserted together with o_Valid = 1.
- Pixels in frames after a failed frame are still emitted. o_Locked reflects the last frame only.
- A one-cycle DEN pulse counts as a line of length 1 (o_LineErr if X_PX != 1).
- A DEN-low gap of exactly VBLANK_MIN_CYCLES-1 is a horizontal blank. A gap of exactly VBLANK_MIN_CYCLES is a vertical blank.
- Reset or standby mid-line: the partial frame is discarded with no error pulses.

Test Plan:
Sim parameters for all scenarios: X_PX = 8, Y_PX = 4, VBLANK_MIN_CYCLES = 20, horizontal blank = 5 cycles, pixel value = {Y,X} pattern.
1. Reset, 25 idle cycles, two good frames -> 32 o_Valid pixels per frame with correct X/Y. SOF at (0,0), 4 EOL pulses, EOF at (7,3). o_Locked rises 20 cycles after the last DEN of frame 1. No error pulses.
2. Frame where line 2 has 7 pixels -> o_LineErr one pulse at that DEN fall. Line 2 has no o_EOL. o_Locked = 0 after the vblank; no o_FrameErr.
3. Frame with 5 lines of 8 -> 5th line produces no o_Valid. o_FrameErr pulses at the vblank and o_Locked drops. The next good frame re-locks.
4. Horizontal gap of 19 vs 20 DEN-low cycles -> 19 continues the frame (Y increments). 20 ends the frame with o_FrameErr if the lines are short.
5. STBYB low mid-line for 1 cycle, then a good frame -> o_Valid = 0 and o_Locked = 0 within 2 edges, no error pulses. Capture resumes only after a 20-cycle gap.
6. Assert i_Reset mid-frame asynchronously -> all outputs 0 immediately. After release, DEN activity before the first 20-cycle gap is ignored.
